// File: rtl/video_stream_checker.sv
// video_stream_checker
//
// Receive-side health monitor for an fv/lv/data pixel stream in the pixel clock domain.
// Measures pixels per line, lines per frame and completed frames. Flags line-length,
// frame-height and lv-outside-fv errors, and asserts lock after LOCK_FRAMES consecutive
// good frames.
//
// Optional feature: define FRAME_CRC_EN to add a per-frame CRC-16-CCITT output (frame_crc).
//
// Ports
//   pix_clk      in   pixel clock, rising edge
//   pix_rst_n    in   synchronous active-low reset
//   fv, lv       in   frame valid / line valid
//   data         in   pixel data, sampled when fv&lv
//   meas_pixels  out  lv-high length of last completed line
//   meas_lines   out  line count of last completed frame
//   frame_cnt    out  completed frames since reset (wraps)
//   frame_done   out  1-cycle pulse per completed frame
//   err_line     out  pulse: completed line length != H_ACTIVE
//   err_frame    out  pulse: completed frame line count != V_ACTIVE
//   err_lv_nofv  out  pulse: lv rising edge while fv low
//   err_sticky   out  {lv_nofv, frame, line} sticky error flags
//   locked       out  stream lock status
//   frame_crc    out  (FRAME_CRC_EN only) CRC-16-CCITT of the last completed frame's pixels

module video_stream_checker #(
    parameter int unsigned H_ACTIVE    = 1920,
    parameter int unsigned V_ACTIVE    = 1080,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        pix_clk,
    input  logic        pix_rst_n,
    input  logic        fv,
    input  logic        lv,
    input  logic [15:0] data,
    output logic [11:0] meas_pixels,
    output logic [11:0] meas_lines,
    output logic [15:0] frame_cnt,
    output logic        frame_done,
    output logic        err_line,
    output logic        err_frame,
    output logic        err_lv_nofv,
    output logic [2:0]  err_sticky,
    output logic        locked
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [11:0] H_EXP    = 12'(H_ACTIVE);
    localparam logic [11:0] V_EXP    = 12'(V_ACTIVE);
    localparam logic [3:0]  LOCK_EXP = 4'(LOCK_FRAMES);

    // Input stage R and its one-cycle-delayed copy used for edge detection
    logic        r_fv_q, r_lv_q, p_fv_q, p_lv_q;
    // Set once R holds a real post-reset sample, so a stale reset value of fv
    // cannot release SYNC in the middle of a frame
    logic        r_vld_q;

    logic [1:0]  state_q, state_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic        seen_err_q, seen_err_d;
    logic [3:0]  good_cnt_q, good_cnt_d;

    logic [11:0] meas_pixels_d, meas_lines_d, lines_total, line_inc;
    logic [15:0] frame_cnt_d;
    logic        frame_done_d, err_line_d, err_frame_d, err_lv_nofv_d, locked_d;
    logic        fv_rise, lv_rise, line_close, good_frame;

    assign fv_rise  = r_fv_q & ~p_fv_q;
    assign lv_rise  = r_lv_q & ~p_lv_q;
    // A line closes on lv fall, or when fv drops while the line is still open
    assign line_close = (state_q == ST_ACTIVE) && p_lv_q && (!r_lv_q || !r_fv_q);
    assign line_inc   = (line_cnt_q == 12'hFFF) ? line_cnt_q : line_cnt_q + 12'd1;

`ifdef FRAME_CRC_EN
    logic [15:0] r_data_q;
    logic [15:0] crc_q, crc_d, frame_crc_d;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc;
        if (state_q == ST_IDLE && fv_rise) begin
            crc_d = r_lv_q ? crc16_step(16'hFFFF, r_data_q) : 16'hFFFF;
        end else if (state_q == ST_ACTIVE) begin
            if (r_fv_q && r_lv_q) crc_d = crc16_step(crc_q, r_data_q);
            if (!r_fv_q)          frame_crc_d = crc_q;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (!pix_rst_n) begin
            r_data_q  <= 16'h0;
            crc_q     <= 16'hFFFF;
            frame_crc <= 16'hFFFF;
        end else begin
            r_data_q  <= data;
            crc_q     <= crc_d;
            frame_crc <= frame_crc_d;
        end
    end
`else
    logic unused_data;
    assign unused_data = ^data;
`endif

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        seen_err_d    = seen_err_q;
        good_cnt_d    = good_cnt_q;
        locked_d      = locked;
        meas_pixels_d = meas_pixels;
        meas_lines_d  = meas_lines;
        frame_cnt_d   = frame_cnt;
        frame_done_d  = 1'b0;
        err_line_d    = 1'b0;
        err_frame_d   = 1'b0;
        err_lv_nofv_d = 1'b0;
        lines_total   = line_cnt_q;
        good_frame    = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (r_vld_q && !r_fv_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (fv_rise) begin
                    state_d    = ST_ACTIVE;
                    line_cnt_d = 12'd0;
                    // fv and lv rising together is a valid first line
                    pix_cnt_d  = r_lv_q ? 12'd1 : 12'd0;
                    seen_err_d = 1'b0;
                end else if (lv_rise && !r_fv_q) begin
                    err_lv_nofv_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (r_fv_q && r_lv_q) begin
                    if (lv_rise)                 pix_cnt_d = 12'd1;
                    else if (pix_cnt_q != 12'hFFF) pix_cnt_d = pix_cnt_q + 12'd1;
                end
                if (line_close) begin
                    meas_pixels_d = pix_cnt_q;
                    line_cnt_d    = line_inc;
                    lines_total   = line_inc;
                    err_line_d    = (pix_cnt_q != H_EXP);
                end
                if (!r_fv_q) begin
                    state_d      = ST_IDLE;
                    meas_lines_d = lines_total;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt + 16'd1;
                    err_frame_d  = (lines_total != V_EXP);
                    good_frame   = !seen_err_q && !err_line_d;
                end
                if (err_line_d) seen_err_d = 1'b1;
            end
            default: state_d = ST_SYNC;
        endcase

        if (err_line_d || err_frame_d || err_lv_nofv_d) begin
            good_cnt_d = 4'd0;
            locked_d   = 1'b0;
        end else if (good_frame) begin
            good_cnt_d = (good_cnt_q >= LOCK_EXP) ? good_cnt_q : good_cnt_q + 4'd1;
            locked_d   = (good_cnt_d == LOCK_EXP);
        end
    end

    always_ff @(posedge pix_clk) begin
        if (!pix_rst_n) begin
            r_fv_q      <= 1'b0;
            r_lv_q      <= 1'b0;
            p_fv_q      <= 1'b0;
            p_lv_q      <= 1'b0;
            r_vld_q     <= 1'b0;
            state_q     <= ST_SYNC;
            pix_cnt_q   <= 12'd0;
            line_cnt_q  <= 12'd0;
            seen_err_q  <= 1'b0;
            good_cnt_q  <= 4'd0;
            meas_pixels <= 12'd0;
            meas_lines  <= 12'd0;
            frame_cnt   <= 16'd0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            err_lv_nofv <= 1'b0;
            err_sticky  <= 3'b000;
            locked      <= 1'b0;
        end else begin
            r_fv_q      <= fv;
            r_lv_q      <= lv;
            p_fv_q      <= r_fv_q;
            p_lv_q      <= r_lv_q;
            r_vld_q     <= 1'b1;
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            seen_err_q  <= seen_err_d;
            good_cnt_q  <= good_cnt_d;
            meas_pixels <= meas_pixels_d;
            meas_lines  <= meas_lines_d;
            frame_cnt   <= frame_cnt_d;
            frame_done  <= frame_done_d;
            err_line    <= err_line_d;
            err_frame   <= err_frame_d;
            err_lv_nofv <= err_lv_nofv_d;
            err_sticky  <= err_sticky | {err_lv_nofv_d, err_frame_d, err_line_d};
            locked      <= locked_d;
        end
    end

endmodule

// File: tb/tb_video_stream_checker.sv
module tb_video_stream_checker;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int LOCK = 2;

    logic        pix_clk = 1'b0;
    logic        pix_rst_n = 1'b0;
    logic        fv = 1'b0, lv = 1'b0;
    logic [15:0] data = 16'h0;
    logic [11:0] meas_pixels, meas_lines;
    logic [15:0] frame_cnt;
    logic        frame_done, err_line, err_frame, err_lv_nofv, locked;
    logic [2:0]  err_sticky;
`ifdef FRAME_CRC_EN
    logic [15:0] frame_crc;
`endif

    video_stream_checker #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .LOCK_FRAMES (LOCK)
    ) dut (
        .pix_clk     (pix_clk),
        .pix_rst_n   (pix_rst_n),
        .fv          (fv),
        .lv          (lv),
        .data        (data),
        .meas_pixels (meas_pixels),
        .meas_lines  (meas_lines),
        .frame_cnt   (frame_cnt),
        .frame_done  (frame_done),
        .err_line    (err_line),
        .err_frame   (err_frame),
        .err_lv_nofv (err_lv_nofv),
        .err_sticky  (err_sticky),
        .locked      (locked)
`ifdef FRAME_CRC_EN
        ,
        .frame_crc   (frame_crc)
`endif
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        int          lines;
        int          pixels;
        bit          err_frame;
        bit          locked;
        int          fcnt;
        logic [2:0]  sticky;
        logic [15:0] crc;
    } frame_rec_t;

    frame_rec_t frame_q[$];
    int         line_q[$];
    frame_rec_t mon_rec;
    int         mon_len;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         good_m = 0;
    bit         locked_m = 1'b0;
    int         frames_m = 0;
    logic [2:0] sticky_m = 3'b000;
    int         nofv_exp = 0;
    int         nofv_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // One frame: tight=1 starts lv with fv and drops both together on the last line
    task automatic drive_frame(input int nlines, input int bad_line, input int bad_len,
                               input bit tight);
        frame_rec_t r;
        bit         line_bad, frame_bad;
        int         len, pix;
        logic [15:0] crc;

        line_bad  = (bad_line >= 0) && (bad_len != H);
        frame_bad = (nlines != V);
        if (line_bad || frame_bad) begin
            good_m   = 0;
            locked_m = 1'b0;
        end else begin
            if (good_m < LOCK) good_m++;
            locked_m = (good_m == LOCK);
        end
        sticky_m = sticky_m | {1'b0, frame_bad, line_bad};
        frames_m = (frames_m + 1) & 16'hFFFF;
        if (line_bad) line_q.push_back(bad_len);

        crc = 16'hFFFF;
        pix = 0;
        @(negedge pix_clk);
        fv = 1'b1;
        if (!tight) repeat (2) @(negedge pix_clk);
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : H;
            for (int p = 0; p < len; p++) begin
                lv   = 1'b1;
                data = 16'(pix);
                crc  = crc_ref(crc, data);
                pix++;
                @(negedge pix_clk);
            end
            lv = 1'b0;
            if (l == nlines - 1 && tight) fv = 1'b0;
            else repeat ((l == nlines - 1) ? 2 : 4) @(negedge pix_clk);
        end
        fv   = 1'b0;
        data = 16'h0;

        r.lines     = nlines;
        r.pixels    = (bad_line == nlines - 1) ? bad_len : H;
        r.err_frame = frame_bad;
        r.locked    = locked_m;
        r.fcnt      = frames_m;
        r.sticky    = sticky_m;
        r.crc       = crc;
        frame_q.push_back(r);
        repeat (6) @(negedge pix_clk);
    endtask

    task automatic drive_lines(input int n, input int len);
        for (int i = 0; i < n; i++) begin
            lv = 1'b1;
            repeat (len) @(negedge pix_clk);
            lv = 1'b0;
            repeat (4) @(negedge pix_clk);
        end
    endtask

    task automatic reset_model();
        good_m   = 0;
        locked_m = 1'b0;
        frames_m = 0;
        sticky_m = 3'b000;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pixels"}, 32'(meas_pixels), 32'd0);
        check({tag, "_lines"},  32'(meas_lines),  32'd0);
        check({tag, "_fcnt"},   32'(frame_cnt),   32'd0);
        check({tag, "_sticky"}, 32'(err_sticky),  32'd0);
        check({tag, "_locked"}, 32'(locked),      32'd0);
        check({tag, "_pulses"}, 32'({frame_done, err_line, err_frame, err_lv_nofv}), 32'd0);
`ifdef FRAME_CRC_EN
        check({tag, "_crc"},    32'(frame_crc),   32'hFFFF);
`endif
    endtask

    // Output monitor: pops expectations as the DUT reports completed frames and errors
    always @(negedge pix_clk) begin
        if (frame_done) begin
            if (frame_q.size() == 0) begin
                check("frame_done_unexp", 32'(frame_done), 32'd0);
            end else begin
                mon_rec = frame_q.pop_front();
                check("meas_lines", 32'(meas_lines), 32'(mon_rec.lines));
                check("meas_pixels_last", 32'(meas_pixels), 32'(mon_rec.pixels));
                check("err_frame", 32'(err_frame), 32'(mon_rec.err_frame));
                check("locked_at_done", 32'(locked), 32'(mon_rec.locked));
                check("frame_cnt", 32'(frame_cnt), 32'(mon_rec.fcnt));
                check("err_sticky_at_done", 32'(err_sticky), 32'(mon_rec.sticky));
`ifdef FRAME_CRC_EN
                check("frame_crc", 32'(frame_crc), 32'(mon_rec.crc));
`endif
            end
        end else if (err_frame) begin
            check("err_frame_without_done", 32'(frame_done), 32'd1);
        end
        if (err_line) begin
            if (line_q.size() == 0) begin
                check("err_line_unexp", 32'(err_line), 32'd0);
            end else begin
                mon_len = line_q.pop_front();
                check("err_line_pixels", 32'(meas_pixels), 32'(mon_len));
            end
        end
        if (err_lv_nofv) nofv_seen++;
    end

    initial begin
        repeat (4) @(negedge pix_clk);
        check_idle_outputs("reset");
        pix_rst_n = 1'b1;
        repeat (5) @(negedge pix_clk);

        // Nominal lock-up
        for (int f = 0; f < 3; f++) drive_frame(V, -1, 0, 1'b0);
        check("nominal_locked", 32'(locked), 32'(locked_m));
        check("nominal_fcnt", 32'(frame_cnt), 32'd3);
        check("nominal_pixels", 32'(meas_pixels), 32'(H));

        // Short line drops lock; two clean frames relock
        drive_frame(V, 3, H - 1, 1'b0);
        drive_frame(V, -1, 0, 1'b0);
        drive_frame(V, -1, 0, 1'b0);

        // lv pulse during vertical blanking
        lv = 1'b1;
        repeat (3) @(negedge pix_clk);
        lv = 1'b0;
        nofv_exp++;
        good_m   = 0;
        locked_m = 1'b0;
        sticky_m = sticky_m | 3'b100;
        repeat (4) @(negedge pix_clk);
        check("nofv_locked", 32'(locked), 32'(locked_m));
        check("nofv_sticky", 32'(err_sticky), 32'(sticky_m));

        // fv/lv rise and fall together, then a tall frame
        drive_frame(V, -1, 0, 1'b1);
        drive_frame(V + 1, -1, 0, 1'b0);
        drive_frame(V, -1, 0, 1'b0);
        check("sticky_persist", 32'(err_sticky), 32'b111);

        // Reset in the middle of a line, released mid-frame
        @(negedge pix_clk);
        fv = 1'b1;
        repeat (2) @(negedge pix_clk);
        drive_lines(1, H);
        lv = 1'b1;
        repeat (5) @(negedge pix_clk);
        pix_rst_n = 1'b0;
        repeat (3) @(negedge pix_clk);
        check_idle_outputs("midreset");
        reset_model();
        pix_rst_n = 1'b1;
        repeat (6) @(negedge pix_clk);
        lv = 1'b0;
        repeat (4) @(negedge pix_clk);
        drive_lines(2, H);
        fv = 1'b0;
        repeat (6) @(negedge pix_clk);
        check("post_reset_fcnt", 32'(frame_cnt), 32'd0);

        drive_frame(V, -1, 0, 1'b0);
        drive_frame(V, -1, 0, 1'b0);
        check("relock_after_reset", 32'(locked), 32'(locked_m));

        repeat (10) @(negedge pix_clk);
        check("frame_q_drained", 32'(frame_q.size()), 32'd0);
        check("line_q_drained", 32'(line_q.size()), 32'd0);
        check("nofv_count", 32'(nofv_seen), 32'(nofv_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
